// File: rtl/cacheline_arbiter.sv
// cacheline_arbiter
//
// Arbitrates between the icache and dcache for a single burst memory port.
// Each granted transaction moves one LineW-bit cacheline as four BurstW-bit
// beats. Read bursts fill an internal line buffer. Write bursts stream the
// dcache writeback line out one beat at a time. After the fourth beat, the
// granted cache gets exactly one cycle of *_resp. The arbiter then returns
// to idle.
//
// Ports
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous active-low reset
//   i_read_i     icache line read request (level, held until i_resp_o)
//   i_addr_i     icache line address
//   i_rdata_o    line buffer, valid while i_resp_o
//   i_resp_o     icache completion pulse
//   d_read_i     dcache line read request (level)
//   d_write_i    dcache line writeback request (level)
//   d_addr_i     dcache line address
//   d_wdata_i    writeback line, beat k taken while beat k is in flight
//   d_rdata_o    line buffer, valid while d_resp_o
//   d_resp_o     dcache completion pulse (read or write)
//   mem_read_o   burst read strobe
//   mem_write_o  burst write strobe
//   mem_addr_o   burst base address, 32-byte aligned
//   mem_wdata_o  current write beat
//   mem_rdata_i  current read beat, valid with mem_resp_i
//   mem_resp_i   one beat accepted/returned this cycle

module cacheline_arbiter #(
  parameter int unsigned LineW  = 256,
  parameter int unsigned BurstW = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,

  input  logic              i_read_i,
  input  logic [31:0]       i_addr_i,
  output logic [LineW-1:0]  i_rdata_o,
  output logic              i_resp_o,

  input  logic              d_read_i,
  input  logic              d_write_i,
  input  logic [31:0]       d_addr_i,
  input  logic [LineW-1:0]  d_wdata_i,
  output logic [LineW-1:0]  d_rdata_o,
  output logic              d_resp_o,

  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [31:0]       mem_addr_o,
  output logic [BurstW-1:0] mem_wdata_o,
  input  logic [BurstW-1:0] mem_rdata_i,
  input  logic              mem_resp_i
);

  typedef enum logic [2:0] {
    StIdle,
    StIRd,
    StDRd,
    StDWr,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         beat_q, beat_d;
  logic [LineW-1:0]   line_q, line_d;
  logic [31:0]        addr_q, addr_d;
  logic               mem_read_q, mem_read_d;
  logic               mem_write_q, mem_write_d;
  // The round-robin pointer is 1 when D took the most recent grant.
  logic               last_d_q, last_d_d;
  // This flag is 1 when the transaction in flight belongs to D. It selects which resp pulses.
  logic               grant_d_q, grant_d_d;

  logic               d_pend;
  logic               pick_d;

  // The low address bits are dropped by alignment.
  logic               unused_addr_bits;
  assign unused_addr_bits = ^{i_addr_i[4:0], d_addr_i[4:0]};

  // D wins when it is the only requester, or when both request and I went last.
  assign d_pend = d_read_i | d_write_i;
  assign pick_d = d_pend & (~i_read_i | ~last_d_q);

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    line_d      = line_q;
    addr_d      = addr_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    last_d_d    = last_d_q;
    grant_d_d   = grant_d_q;

    unique case (state_q)
      StIdle: begin
        if (d_pend || i_read_i) begin
          last_d_d  = pick_d;
          grant_d_d = pick_d;
          beat_d    = 2'd0;
          if (pick_d) begin
            addr_d = {d_addr_i[31:5], 5'b0};
            // A simultaneous read and write from D goes out as a write.
            if (d_write_i) begin
              state_d     = StDWr;
              mem_write_d = 1'b1;
            end else begin
              state_d    = StDRd;
              mem_read_d = 1'b1;
            end
          end else begin
            addr_d     = {i_addr_i[31:5], 5'b0};
            state_d    = StIRd;
            mem_read_d = 1'b1;
          end
        end
      end

      StIRd, StDRd, StDWr: begin
        // Only beats acknowledged by memory advance the burst. Gaps hold everything.
        if (mem_resp_i) begin
          if (state_q != StDWr) begin
            line_d[32'(beat_q) * BurstW +: BurstW] = mem_rdata_i;
          end
          if (beat_q == 2'd3) begin
            state_d     = StDone;
            beat_d      = 2'd0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end
      end

      // A single resp cycle follows. A new grant is never taken from here.
      StDone: state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      beat_q      <= 2'd0;
      line_q      <= '0;
      addr_q      <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      last_d_q    <= 1'b0;
      grant_d_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      line_q      <= line_d;
      addr_q      <= addr_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      last_d_q    <= last_d_d;
      grant_d_q   <= grant_d_d;
    end
  end

  // The write beat is steered from the beat counter. It is quiet outside write bursts.
  always_comb begin
    mem_wdata_o = '0;
    if (state_q == StDWr) begin
      mem_wdata_o = d_wdata_i[32'(beat_q) * BurstW +: BurstW];
    end
  end

  assign mem_read_o  = mem_read_q;
  assign mem_write_o = mem_write_q;
  assign mem_addr_o  = addr_q;
  assign i_rdata_o   = line_q;
  assign d_rdata_o   = line_q;
  assign i_resp_o    = (state_q == StDone) & ~grant_d_q;
  assign d_resp_o    = (state_q == StDone) &  grant_d_q;

endmodule

// File: tb/tb_cacheline_arbiter.sv
module tb_cacheline_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_read;
  logic [31:0]  i_addr;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic         d_read;
  logic         d_write;
  logic [31:0]  d_addr;
  logic [255:0] d_wdata;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_addr;
  logic [63:0]  mem_wdata;
  logic [63:0]  mem_rdata;
  logic         mem_resp;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cacheline_arbiter dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .i_read_i    (i_read),
    .i_addr_i    (i_addr),
    .i_rdata_o   (i_rdata),
    .i_resp_o    (i_resp),
    .d_read_i    (d_read),
    .d_write_i   (d_write),
    .d_addr_i    (d_addr),
    .d_wdata_i   (d_wdata),
    .d_rdata_o   (d_rdata),
    .d_resp_o    (d_resp),
    .mem_read_o  (mem_read),
    .mem_write_o (mem_write),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .mem_resp_i  (mem_resp)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_read    = 1'b0;
    d_read    = 1'b0;
    d_write   = 1'b0;
    mem_resp  = 1'b0;
    mem_rdata = '0;
  endtask

  // Zero-wait memory: return the four beats of line on consecutive edges.
  task automatic feed_beats(input logic [255:0] line);
    for (int b = 0; b < 4; b++) begin
      mem_resp  = 1'b1;
      mem_rdata = line[b*64 +: 64];
      tick();
    end
    mem_resp  = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    i_addr  = 32'hFFFF_FFFF;
    d_addr  = 32'hFFFF_FFFF;
    d_wdata = {4{64'hFFFF_FFFF_FFFF_FFFF}};
    rst_n   = 1'b0;
    tick();
    tick();
    total++;
    if ({i_resp, d_resp, mem_read, mem_write} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 0000", {i_resp, d_resp, mem_read, mem_write});
    end
    total++;
    if (mem_addr !== 32'h0) begin
      bad++;
      $display("FAIL reset_addr: got %h want 0", mem_addr);
    end
    total++;
    if (mem_wdata !== 64'h0) begin
      bad++;
      $display("FAIL reset_wdata: got %h want 0", mem_wdata);
    end
    total++;
    if (i_rdata !== 256'h0 || d_rdata !== 256'h0) begin
      bad++;
      $display("FAIL reset_rdata: got %h / %h want 0", i_rdata, d_rdata);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_i_read();
    logic [255:0] exp_line;
    exp_line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    i_addr = 32'h0000_0064;
    i_read = 1'b1;
    tick();
    total++;
    if ({mem_read, mem_write} !== 2'b10) begin
      bad++;
      $display("FAIL i_rd_strobe: got %b want 10", {mem_read, mem_write});
    end
    total++;
    if (mem_addr !== 32'h0000_0060) begin
      bad++;
      $display("FAIL i_rd_addr: got %h want 00000060", mem_addr);
    end
    for (int b = 0; b < 4; b++) begin
      mem_resp  = 1'b1;
      mem_rdata = exp_line[b*64 +: 64];
      tick();
      if (b < 3) begin
        total++;
        if (i_resp !== 1'b0 || mem_read !== 1'b1) begin
          bad++;
          $display("FAIL i_rd_mid beat%0d: resp=%b rd=%b want 0 1", b, i_resp, mem_read);
        end
      end
    end
    mem_resp = 1'b0;
    i_read   = 1'b0;
    total++;
    if ({i_resp, d_resp, mem_read} !== 3'b100) begin
      bad++;
      $display("FAIL i_rd_done: got %b want 100", {i_resp, d_resp, mem_read});
    end
    total++;
    if (i_rdata !== exp_line) begin
      bad++;
      $display("FAIL i_rd_data: got %h want %h", i_rdata, exp_line);
    end
    tick();
    total++;
    if ({i_resp, mem_read} !== 2'b00) begin
      bad++;
      $display("FAIL i_rd_after: got %b want 00", {i_resp, mem_read});
    end
  endtask

  task automatic test_d_write();
    logic [255:0] prev_line;
    prev_line = i_rdata;
    d_addr  = 32'h1234_567C;
    d_wdata = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
    d_write = 1'b1;
    tick();
    total++;
    if ({mem_read, mem_write} !== 2'b01 || mem_addr !== 32'h1234_5660) begin
      bad++;
      $display("FAIL d_wr_grant: got %b %h want 01 12345660", {mem_read, mem_write}, mem_addr);
    end
    for (int b = 0; b < 4; b++) begin
      total++;
      if (mem_wdata !== 64'(64'hA0 + b)) begin
        bad++;
        $display("FAIL d_wr_beat%0d: got %h want %h", b, mem_wdata, 64'(64'hA0 + b));
      end
      mem_resp = 1'b1;
      tick();
    end
    mem_resp = 1'b0;
    d_write  = 1'b0;
    total++;
    if ({d_resp, i_resp, mem_write} !== 3'b100) begin
      bad++;
      $display("FAIL d_wr_done: got %b want 100", {d_resp, i_resp, mem_write});
    end
    total++;
    if (d_rdata !== prev_line) begin
      bad++;
      $display("FAIL d_wr_buf_kept: got %h want %h", d_rdata, prev_line);
    end
    tick();
    total++;
    if ({d_resp, mem_write} !== 2'b00) begin
      bad++;
      $display("FAIL d_wr_after: got %b want 00", {d_resp, mem_write});
    end
  endtask

  task automatic test_arbitration();
    logic [255:0] ld;
    logic [255:0] li;
    ld = {64'hD4, 64'hD3, 64'hD2, 64'hD1};
    li = {64'hE4, 64'hE3, 64'hE2, 64'hE1};
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n  = 1'b1;
    tick();
    i_addr = 32'h0000_0100;
    d_addr = 32'h0000_0200;
    i_read = 1'b1;
    d_read = 1'b1;
    tick();
    total++;
    if (mem_addr !== 32'h0000_0200 || mem_read !== 1'b1) begin
      bad++;
      $display("FAIL arb_first_d: got %h rd=%b want 00000200 1", mem_addr, mem_read);
    end
    feed_beats(ld);
    d_read = 1'b0;
    total++;
    if ({d_resp, i_resp} !== 2'b10 || d_rdata !== ld) begin
      bad++;
      $display("FAIL arb_d_done: got %b %h want 10 %h", {d_resp, i_resp}, d_rdata, ld);
    end
    tick();
    total++;
    if ({mem_read, i_resp, d_resp} !== 3'b000) begin
      bad++;
      $display("FAIL arb_no_overlap: got %b want 000", {mem_read, i_resp, d_resp});
    end
    tick();
    total++;
    if (mem_addr !== 32'h0000_0100 || mem_read !== 1'b1) begin
      bad++;
      $display("FAIL arb_then_i: got %h rd=%b want 00000100 1", mem_addr, mem_read);
    end
    feed_beats(li);
    i_read = 1'b0;
    total++;
    if ({i_resp, d_resp} !== 2'b10 || i_rdata !== li) begin
      bad++;
      $display("FAIL arb_i_done: got %b %h want 10 %h", {i_resp, d_resp}, i_rdata, li);
    end
    tick();
    d_addr = 32'h0000_0300;
    i_read = 1'b1;
    d_read = 1'b1;
    tick();
    total++;
    if (mem_addr !== 32'h0000_0300) begin
      bad++;
      $display("FAIL arb_second_tie_d: got %h want 00000300", mem_addr);
    end
    feed_beats(ld);
    idle_inputs();
    tick();
  endtask

  task automatic test_gaps();
    logic [6:0]   pat;
    logic [255:0] exp_line;
    int           j;
    pat      = 7'b1011001;
    exp_line = {64'hC4, 64'hC3, 64'hC2, 64'hC1};
    j        = 0;
    d_addr = 32'h4000_0040;
    d_read = 1'b1;
    tick();
    for (int c = 0; c < 7; c++) begin
      mem_resp = pat[c];
      if (pat[c]) begin
        mem_rdata = exp_line[j*64 +: 64];
        j++;
      end else begin
        mem_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
      end
      if (c == 2) d_read = 1'b0;
      tick();
      total++;
      if (c < 6) begin
        if ({d_resp, mem_read} !== 2'b01) begin
          bad++;
          $display("FAIL gap_cycle%0d: resp/rd got %b want 01", c, {d_resp, mem_read});
        end
      end else if ({d_resp, mem_read} !== 2'b10) begin
        bad++;
        $display("FAIL gap_done: resp/rd got %b want 10", {d_resp, mem_read});
      end
    end
    mem_resp = 1'b0;
    total++;
    if (d_rdata !== exp_line) begin
      bad++;
      $display("FAIL gap_data: got %h want %h", d_rdata, exp_line);
    end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    logic [255:0] l5;
    l5 = {64'h5555_0004, 64'h5555_0003, 64'h5555_0002, 64'h5555_0001};
    i_addr = 32'h0000_0080;
    i_read = 1'b1;
    tick();
    for (int b = 0; b < 2; b++) begin
      mem_resp  = 1'b1;
      mem_rdata = 64'h7777_0000 + 64'(b);
      tick();
    end
    idle_inputs();
    rst_n = 1'b0;
    tick();
    total++;
    if ({mem_read, mem_write, i_resp, d_resp} !== 4'b0000 || mem_addr !== 32'h0) begin
      bad++;
      $display("FAIL rst_mid_ctrl: got %b %h want 0000 0",
               {mem_read, mem_write, i_resp, d_resp}, mem_addr);
    end
    total++;
    if (i_rdata !== 256'h0) begin
      bad++;
      $display("FAIL rst_mid_buf: got %h want 0", i_rdata);
    end
    rst_n = 1'b1;
    tick();
    i_read = 1'b1;
    tick();
    for (int b = 0; b < 4; b++) begin
      mem_resp  = 1'b1;
      mem_rdata = l5[b*64 +: 64];
      tick();
      if (b < 3) begin
        total++;
        if (i_resp !== 1'b0) begin
          bad++;
          $display("FAIL rst_restart_beat%0d: resp got %b want 0", b, i_resp);
        end
      end
    end
    idle_inputs();
    total++;
    if (i_resp !== 1'b1 || i_rdata !== l5) begin
      bad++;
      $display("FAIL rst_restart_done: got %b %h want 1 %h", i_resp, i_rdata, l5);
    end
    tick();
  endtask

  task automatic test_write_priority();
    // A stray beat ack while idle must not move the counter.
    mem_resp = 1'b1;
    tick();
    tick();
    total++;
    if ({mem_read, mem_write, i_resp, d_resp} !== 4'b0000) begin
      bad++;
      $display("FAIL stray_resp: got %b want 0000", {mem_read, mem_write, i_resp, d_resp});
    end
    mem_resp = 1'b0;
    d_addr  = 32'h8000_0020;
    d_wdata = {64'hB3, 64'hB2, 64'hB1, 64'hB0};
    d_read  = 1'b1;
    d_write = 1'b1;
    tick();
    total++;
    if ({mem_read, mem_write} !== 2'b01 || mem_addr !== 32'h8000_0020) begin
      bad++;
      $display("FAIL wr_wins: got %b %h want 01 80000020", {mem_read, mem_write}, mem_addr);
    end
    for (int b = 0; b < 4; b++) begin
      total++;
      if (mem_wdata !== 64'(64'hB0 + b)) begin
        bad++;
        $display("FAIL wr_wins_beat%0d: got %h want %h", b, mem_wdata, 64'(64'hB0 + b));
      end
      mem_resp = 1'b1;
      tick();
    end
    mem_resp = 1'b0;
    total++;
    if ({d_resp, mem_write} !== 2'b10) begin
      bad++;
      $display("FAIL wr_wins_done: got %b want 10", {d_resp, mem_write});
    end
    // The request is still high, so a fresh transaction follows the idle cycle.
    tick();
    total++;
    if ({d_resp, mem_write} !== 2'b00) begin
      bad++;
      $display("FAIL b2b_idle: got %b want 00", {d_resp, mem_write});
    end
    tick();
    total++;
    if (mem_write !== 1'b1 || mem_wdata !== 64'hB0) begin
      bad++;
      $display("FAIL b2b_regrant: got %b %h want 1 b0", mem_write, mem_wdata);
    end
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n   = 1'b0;
    i_addr  = '0;
    d_addr  = '0;
    d_wdata = '0;
    idle_inputs();
    test_reset();
    test_i_read();
    test_d_write();
    test_arbitration();
    test_gaps();
    test_reset_mid_burst();
    test_write_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
